// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared constants, FSM state type and reference truth table for the gate sweep checker
package gate_sweep_pkg;
    localparam int NUM_GATES    = 7;
    localparam int NUM_PATTERNS = 4;
    localparam int GATE_BUF  = 0;
    localparam int GATE_NOT  = 1;
    localparam int GATE_AND  = 2;
    localparam int GATE_OR   = 3;
    localparam int GATE_XOR  = 4;
    localparam int GATE_NAND = 5;
    localparam int GATE_NOR  = 6;

    typedef enum logic {IDLE, DRIVE} state_t;

    function automatic logic [NUM_GATES-1:0] expect_gates(input logic a, input logic b);
        logic [NUM_GATES-1:0] r;
        r[GATE_BUF]  = a;
        r[GATE_NOT]  = ~a;
        r[GATE_AND]  = a & b;
        r[GATE_OR]   = a | b;
        r[GATE_XOR]  = a ^ b;
        r[GATE_NAND] = ~(a & b);
        r[GATE_NOR]  = ~(a | b);
        return r;
    endfunction
endpackage

// File: rtl/sweep_hold_timer.sv
// sweep_hold_timer: loadable down-counter that flags the last cycle of each pattern hold window
module sweep_hold_timer #(
    parameter int HOLD_CYCLES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);
    localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? CW'(HOLD_CYCLES - 1) : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = cnt_q == '0;
endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps a/b through 00..11 and checks logic_gate outputs against the truth table
// Optional continuous back-to-back sweeping while start stays high: GATE_SWEEP_CONT_EN
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 5,
    parameter int ERR_CNT_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    a,
    output logic                    b,
    input  logic [NUM_GATES-1:0]    gate_res,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ERR_CNT_W-1:0]    err_cnt,
    output logic [NUM_GATES-1:0]    err_mask,
    output logic [NUM_PATTERNS-1:0] fail_vec
);
    localparam int SW = ERR_CNT_W + 4;
    localparam logic [SW-1:0] CNT_MAX = SW'((1 << ERR_CNT_W) - 1);

    state_t                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic                    done_q, done_d, pass_q, pass_d;
    logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [NUM_GATES-1:0]    err_mask_q, err_mask_d, mism;
    logic [NUM_PATTERNS-1:0] fail_vec_q, fail_vec_d;
    logic [SW-1:0]           sum;
    logic                    tmr_zero, launch, sample, last, cont;

`ifdef GATE_SWEEP_CONT_EN
    assign cont = start;
`else
    assign cont = 1'b0;
`endif

    assign launch = state_q == IDLE && start;
    assign sample = state_q == DRIVE && tmr_zero;
    assign last   = sample && idx_q == 2'd3;

    sweep_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (launch | sample),
        .en    (state_q == DRIVE),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_mask_q <= '0;
            fail_vec_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            err_mask_q <= err_mask_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    always_comb state_d = state_q == IDLE ? (start ? DRIVE : IDLE) : (last && !cont ? IDLE : DRIVE);

    // idx wraps 3->0 naturally, so a/b return to 00 after the final pattern
    always_comb begin
        idx_d      = idx_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        err_mask_d = err_mask_q;
        fail_vec_d = fail_vec_q;
        mism       = gate_res ^ expect_gates(idx_q[1], idx_q[0]);
        sum        = SW'(err_cnt_q) + SW'($countones(mism));
        if (launch) begin
            idx_d      = '0;
            pass_d     = 1'b0;
            err_cnt_d  = '0;
            err_mask_d = '0;
            fail_vec_d = '0;
        end else if (sample) begin
            err_cnt_d         = sum > CNT_MAX ? ERR_CNT_W'(CNT_MAX) : ERR_CNT_W'(sum);
            err_mask_d        = err_mask_q | mism;
            fail_vec_d[idx_q] = |mism;
            idx_d             = idx_q + 1'b1;
            if (last) begin
                done_d = 1'b1;
                pass_d = ~|err_mask_d;
            end
        end
    end

    always_comb begin
        busy = state_q == DRIVE;
        a    = idx_q[1];
        b    = idx_q[0];
    end

    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign err_mask = err_mask_q;
    assign fail_vec = fail_vec_q;
endmodule
